// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, widths and FSM states.
// Imported by the issuer, its interface and the settle timer.
package alu_pkg;

    localparam int OP_W    = 3;
    localparam int DATA_W  = 4;
    localparam int CNT_W   = 4;
    localparam int ISSUE_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_CLR = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_OR  = 3'b011,
        OP_AND = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command and response handshakes of the ALU command issuer.
// The master side offers commands and takes responses; the slave side is the issuer.
interface alu_cmd_issuer_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_chain;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [OP_W-1:0]   rsp_op;
    logic [DATA_W-1:0] rsp_f;
    logic              rsp_z;
    logic              rsp_c;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_op, rsp_f, rsp_z, rsp_c
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
        output cmd_ready, rsp_valid, rsp_op, rsp_f, rsp_z, rsp_c
    );

endinterface

// File: rtl/alu_settle_timer.sv
// Down-counter that times the ALU settle window: load, decrement, zero flag.
// The count never underflows; it rests at zero until the next load.
module alu_settle_timer
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to a combinational ALU, waits SETTLE_CYCLES, returns the result.
// Optional result chaining into operand A is enabled by defining ALU_CMD_ISSUER_CHAIN_EN.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_issuer_if.slave    bus,
    output logic [OP_W-1:0]    alu_s,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_f,
    input  logic               alu_z,
    input  logic               alu_c,
    output logic [ISSUE_W-1:0] issue_cnt
);

    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ISSUE_W-1:0] ISSUE_ONE   = 1;

    state_e            state;
    logic              take_cmd;
    logic              take_rsp;
    logic              settle_done;
    logic [DATA_W-1:0] a_next;

    assign take_cmd = (state == IDLE) && bus.cmd_valid && bus.cmd_ready;
    assign take_rsp = (state == RESP) && bus.rsp_valid && bus.rsp_ready;

    alu_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (take_cmd),
        .load_val (SETTLE_LOAD),
        .dec      (state == DRIVE),
        .zero     (settle_done)
    );

`ifdef ALU_CMD_ISSUER_CHAIN_EN
    // rsp_f still holds the last accepted result while idle, so it doubles as the chain source.
    logic chain_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_valid <= 1'b0;
        end else if (take_rsp) begin
            chain_valid <= 1'b1;
        end
    end

    // NOTE: the default assignment ahead of the condition keeps this combinational block latch-free.
    always_comb begin
        a_next = bus.cmd_a;
        if (bus.cmd_chain && chain_valid) begin
            a_next = bus.rsp_f;
        end
    end
`else
    logic unused_chain;
    assign unused_chain = bus.cmd_chain;
    assign a_next       = bus.cmd_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_op    <= '0;
            bus.rsp_f     <= '0;
            bus.rsp_z     <= 1'b0;
            bus.rsp_c     <= 1'b0;
            alu_s         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            issue_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_cmd) begin
                        alu_s         <= bus.cmd_op;
                        alu_a         <= a_next;
                        alu_b         <= bus.cmd_b;
                        bus.rsp_op    <= bus.cmd_op;
                        bus.cmd_ready <= 1'b0;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_done) begin
                        bus.rsp_f     <= alu_f;
                        bus.rsp_z     <= alu_z;
                        bus.rsp_c     <= alu_c;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    // Ready returns one edge after the response handshake: no same-edge bypass.
                    if (take_rsp) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        issue_cnt     <= issue_cnt + ISSUE_ONE;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: transaction-level reference model plus directed cases.
// Two instances: SETTLE_CYCLES=1 (model-checked every cycle) and SETTLE_CYCLES=3 (latency/reset).
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int S1 = 1;
    localparam int S3 = 3;
`ifdef ALU_CMD_ISSUER_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rst3_n;
    always #5 clk = ~clk;

    // Reference ALU: returns {z, c, f}.
    function automatic logic [5:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] w;
        case (op)
            3'b000:  w = 5'd0;
            3'b001:  w = {1'b0, a} + {1'b0, b};
            3'b010:  w = {1'b0, a} - {1'b0, b};
            3'b011:  w = {1'b0, a | b};
            3'b100:  w = {1'b0, a & b};
            3'b101:  w = {1'b0, a ^ b};
            3'b110:  w = {a, 1'b0};
            default: w = {a[0], 1'b0, a[3:1]};
        endcase
        return {(w[3:0] == 4'd0), w[4], w[3:0]};
    endfunction

    alu_cmd_issuer_if b1 ();
    alu_cmd_issuer_if b3 ();

    logic [2:0] s1, s3;
    logic [3:0] a1, bb1, f1, a3, bb3, f3;
    logic       z1, c1, z3, c3;
    logic [7:0] cnt1, cnt3;

    assign {z1, c1, f1} = alu_ref(s1, a1, bb1);
    assign {z3, c3, f3} = alu_ref(s3, a3, bb3);

    alu_cmd_issuer #(.SETTLE_CYCLES(S1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave),
        .alu_s(s1), .alu_a(a1), .alu_b(bb1), .alu_f(f1), .alu_z(z1), .alu_c(c1),
        .issue_cnt(cnt1)
    );

    alu_cmd_issuer #(.SETTLE_CYCLES(S3)) u3 (
        .clk(clk), .rst_n(rst3_n), .bus(b3.slave),
        .alu_s(s3), .alu_a(a3), .alu_b(bb3), .alu_f(f3), .alu_z(z3), .alu_c(c3),
        .issue_cnt(cnt3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction model for u1: one command in flight, response visible S1 edges after accept.
    int         edge_n      = 0;
    int         m_acc       = 0;
    int         m_resp_edge = -1;
    bit         m_busy      = 0;
    int         m_cnt       = 0;
    bit         m_have_prev = 0;
    logic [3:0] m_prev_f    = '0;
    logic [2:0] m_op = '0, m_s = '0;
    logic [3:0] m_f = '0, m_a = '0, m_b = '0;
    logic       m_z = 0, m_c = 0;
    bit         chk_on = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_cnt = 0; m_have_prev = 0; m_prev_f = '0;
            m_op = '0; m_s = '0; m_f = '0; m_a = '0; m_b = '0; m_z = 0; m_c = 0;
        end else begin
            edge_n++;
            if (m_busy && (edge_n - 1 - m_acc >= S1) && b1.rsp_ready) begin
                m_busy      = 0;
                m_cnt       = (m_cnt + 1) % 256;
                m_prev_f    = m_f;
                m_have_prev = 1;
                m_resp_edge = edge_n;
            end else if (!m_busy && b1.cmd_valid) begin
                m_busy = 1;
                m_acc  = edge_n;
                m_op   = b1.cmd_op;
                m_s    = b1.cmd_op;
                m_a    = (CHAIN && b1.cmd_chain && m_have_prev) ? m_prev_f : b1.cmd_a;
                m_b    = b1.cmd_b;
                {m_z, m_c, m_f} = alu_ref(m_op, m_a, m_b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            bit ev;
            ev = m_busy && (edge_n - m_acc >= S1);
            check("cmd_ready", b1.cmd_ready, !m_busy);
            check("rsp_valid", b1.rsp_valid, ev);
            check("issue_cnt", cnt1, m_cnt);
            check("alu_s", s1, m_s);
            check("alu_a", a1, m_a);
            check("alu_b", bb1, m_b);
            if (ev) begin
                check("rsp_op", b1.rsp_op, m_op);
                check("rsp_f", b1.rsp_f, m_f);
                check("rsp_z", b1.rsp_z, m_z);
                check("rsp_c", b1.rsp_c, m_c);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ch);
        bit done = 0;
        b1.cmd_op = op; b1.cmd_a = a; b1.cmd_b = b; b1.cmd_chain = ch; b1.cmd_valid = 1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(posedge clk); #1;
            if (m_busy && m_acc == edge_n) done = 1;
        end
        b1.cmd_valid = 0;
        check("issue_accept", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rst_n = 0; rst3_n = 0;
        b1.cmd_valid = 0; b1.cmd_op = '0; b1.cmd_a = '0; b1.cmd_b = '0; b1.cmd_chain = 0; b1.rsp_ready = 1;
        b3.cmd_valid = 0; b3.cmd_op = '0; b3.cmd_a = '0; b3.cmd_b = '0; b3.cmd_chain = 0; b3.rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1; rst3_n = 1;
        chk_on = 1;
        @(negedge clk);
        check("reset_ready", b1.cmd_ready, 1);
        check("reset_valid", b1.rsp_valid, 0);
        check("reset_cnt", cnt1, 0);

        // add 1001+0111 -> 0000, carry, zero; one edge latency
        issue(OP_ADD, 4'b1001, 4'b0111, 0);
        @(negedge clk); check("add_lat_early", b1.rsp_valid, 0);
        @(negedge clk);
        check("add_valid", b1.rsp_valid, 1);
        check("add_f", b1.rsp_f, 4'b0000);
        check("add_c", b1.rsp_c, 1);
        check("add_z", b1.rsp_z, 1);
        @(negedge clk); check("add_cnt", cnt1, 1);

        issue(OP_SUB, 4'b0000, 4'b0001, 0);
        repeat (2) @(negedge clk);
        check("sub_borrow_f", b1.rsp_f, 4'b1111);
        check("sub_borrow_c", b1.rsp_c, 1);
        check("sub_borrow_z", b1.rsp_z, 0);
        issue(OP_SUB, 4'b0111, 4'b0111, 0);
        repeat (2) @(negedge clk);
        check("sub_eq_f", b1.rsp_f, 4'b0000);
        check("sub_eq_z", b1.rsp_z, 1);

        // backpressure: response held, stray commands ignored
        @(negedge clk);
        b1.rsp_ready = 0;
        issue(OP_XOR, 4'b1111, 4'b1010, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp_ready", b1.cmd_ready, 0);
            if (i >= 1) begin
                check("bp_valid", b1.rsp_valid, 1);
                check("bp_f", b1.rsp_f, 4'b0101);
            end
            b1.cmd_valid = i[0];
            b1.cmd_a = 4'($urandom);
            b1.cmd_op = 3'($urandom);
        end
        b1.cmd_valid = 0;
        b1.rsp_ready = 1;
        repeat (2) @(negedge clk);

        // chaining
        issue(OP_ADD, 4'b0011, 4'b0101, 0);
        repeat (2) @(negedge clk);
        check("chain_first_f", b1.rsp_f, 4'b1000);
        issue(OP_ADD, 4'b0010, 4'b0001, 1);
        @(negedge clk); check("chain_alu_a", a1, CHAIN ? 4'b1000 : 4'b0010);
        @(negedge clk); check("chain_f", b1.rsp_f, CHAIN ? 4'b1001 : 4'b0011);
        @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            b1.cmd_valid = ($urandom_range(0, 99) < 60);
            b1.cmd_op    = 3'($urandom);
            b1.cmd_a     = 4'($urandom);
            b1.cmd_b     = 4'($urandom);
            b1.cmd_chain = 1'($urandom);
            b1.rsp_ready = ($urandom_range(0, 99) < 65);
        end
        @(negedge clk);
        b1.cmd_valid = 0; b1.rsp_ready = 1; b1.cmd_chain = 0;
        repeat (4) @(negedge clk);

        // reset, then 256 back-to-back shl commands wrap the counter
        @(posedge clk); #1 rst_n = 0;
        #2;
        check("rst1_valid", b1.rsp_valid, 0);
        check("rst1_cnt", cnt1, 0);
        check("rst1_alu_a", a1, 0);
        @(posedge clk); #1 rst_n = 1;
        b1.cmd_op = OP_SHL; b1.cmd_a = 4'b0011; b1.cmd_b = 4'b0000; b1.cmd_valid = 1;
        got = 0;
        for (int i = 0; i < 1200 && got < 256; i++) begin
            @(posedge clk); #1;
            if (m_resp_edge == edge_n) begin
                got++;
                if (got == 255) check("cnt_255", cnt1, 255);
            end
        end
        b1.cmd_valid = 0;
        check("wrap_responses", got, 256);
        check("cnt_wrap", cnt1, 0);
        repeat (3) @(negedge clk);
        chk_on = 0;

        // SETTLE_CYCLES=3 instance: latency
        @(posedge clk); #1;
        b3.cmd_op = OP_ADD; b3.cmd_a = 4'd1; b3.cmd_b = 4'd2; b3.cmd_valid = 1; b3.rsp_ready = 0;
        @(posedge clk); #1 b3.cmd_valid = 0;
        check("s3_busy", b3.cmd_ready, 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); check("s3_wait", b3.rsp_valid, 0);
        end
        @(negedge clk);
        check("s3_valid", b3.rsp_valid, 1);
        check("s3_f", b3.rsp_f, 4'd3);
        check("s3_alu_a", a3, 4'd1);
        b3.rsp_ready = 1;
        @(negedge clk);
        check("s3_done", b3.rsp_valid, 0);
        check("s3_cnt", cnt3, 1);

        // reset one edge into DRIVE abandons the command
        @(posedge clk); #1;
        b3.cmd_op = OP_SUB; b3.cmd_a = 4'd5; b3.cmd_b = 4'd1; b3.cmd_valid = 1;
        @(posedge clk); #1 b3.cmd_valid = 0;
        @(posedge clk); #1 rst3_n = 0;
        #2;
        check("s3_rst_valid", b3.rsp_valid, 0);
        check("s3_rst_cnt", cnt3, 0);
        check("s3_rst_alu_s", s3, 0);
        @(posedge clk); #1 rst3_n = 1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("s3_post_valid", b3.rsp_valid, 0);
            check("s3_post_ready", b3.cmd_ready, 1);
            check("s3_post_cnt", cnt3, 0);
        end
        @(posedge clk); #1;
        b3.cmd_op = OP_OR; b3.cmd_a = 4'b1100; b3.cmd_b = 4'b0011; b3.cmd_valid = 1;
        @(posedge clk); #1 b3.cmd_valid = 0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("s3_or_valid", b3.rsp_valid, 1);
        check("s3_or_f", b3.rsp_f, 4'b1111);
        @(negedge clk);
        check("s3_or_cnt", cnt3, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, ALU combinational settle time in clk cycles (legal 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  issuer can accept a command.
REQ-006 cmd_op  input  3  ALU opcode (000 clear, 001 add, 010 sub, 011 or, 100 and, 101 xor, 110 shl, 111 shr).
REQ-007 cmd_a, cmd_b  input  4 each  operands.
REQ-008 cmd_chain  input  1  substitute previous result for A (see Configuration).
REQ-009 alu_s  output  3; alu_a, alu_b  output  4 each  registered drive to ALU S/A/B.
REQ-010 alu_f  input  4; alu_z, alu_c  input  1 each  ALU result, zero flag, carry/borrow flag.
REQ-011 rsp_valid  output  1; rsp_ready  input  1  result handshake.
REQ-012 rsp_op  output  3; rsp_f  output  4; rsp_z, rsp_c  output  1 each  captured opcode/result/flags.
REQ-013 issue_cnt  output  8  count of completed responses.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, RESP; reset state IDLE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; transfer occurs on cmd_valid & cmd_ready at a rising edge.
REQ-016 On transfer: alu_s/alu_a/alu_b and rsp_op SHALL load from command at that edge; state -> DRIVE; settle counter loads SETTLE_CYCLES-1.
REQ-017 DRIVE: counter decrements each cycle; at the edge where counter is 0, rsp_f/rsp_z/rsp_c SHALL sample alu_f/alu_z/alu_c, rsp_valid -> 1, state -> RESP.
REQ-018 Latency: command accepted at edge k -> rsp_valid high after edge k+SETTLE_CYCLES.
REQ-019 RESP: rsp_* SHALL hold stable while rsp_ready=0; on rsp_valid & rsp_ready, rsp_valid -> 0, issue_cnt +1, state -> IDLE.
REQ-020 No bypass: cmd_ready SHALL stay 0 in the cycle a response is accepted; next command accepted no earlier than following edge.
REQ-021 alu_s/alu_a/alu_b SHALL hold last issued values between commands.
REQ-022 issue_cnt SHALL wrap 255 -> 0.
REQ-023 cmd_valid in DRIVE/RESP SHALL be ignored (no capture, no error).

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, cmd_ready 1 after release, rsp_valid 0, all alu_*, rsp_*, issue_cnt, settle counter, chain-valid flag 0.
REQ-025 Reset mid-DRIVE or mid-RESP SHALL abandon the command with no response and no count increment.

Configuration
REQ-026 Macro ALU_CMD_ISSUER_CHAIN_EN defined: if cmd_chain=1 and a prior response has been accepted since reset, alu_a SHALL load the last accepted rsp_f instead of cmd_a; otherwise cmd_a.
REQ-027 Macro undefined: cmd_chain port SHALL exist but be ignored; alu_a always loads cmd_a; no chain-valid flag implemented.

Structure
REQ-028 Shared package alu_pkg SHALL hold the opcode constants (8 values), operand width 4, and the FSM state typedef.
REQ-029 Settle counter SHALL be a sub-module alu_settle_timer (load, decrement, zero flag); remainder flat.

Verification
REQ-030 Add 1001+0111, SETTLE=1, rsp_ready=1 -> rsp_f=0000, rsp_c=1, rsp_z=1, rsp_valid one edge after accept, issue_cnt=1.
REQ-031 Sub 0000-0001 -> rsp_f=1111, rsp_c=1 (borrow), rsp_z=0; sub 0111-0111 -> rsp_f=0000, rsp_z=1.
REQ-032 rsp_ready held 0 for 5 cycles after xor 1111^1010 -> rsp_f=0101 stable, cmd_ready=0 throughout, cmd_valid pulses ignored.
REQ-033 Chain (macro on): add 0011+0101 -> 1000; then add chain=1, b=0001 -> alu_a=1000, rsp_f=1001; macro off same stimulus -> alu_a=cmd_a.
REQ-034 SETTLE_CYCLES=3: accept at edge k -> rsp_valid at k+3; rst_n pulsed low at k+1 -> no response, issue_cnt unchanged, cmd_ready=1 after release.
REQ-035 256 back-to-back shl commands -> issue_cnt wraps to 0.
